// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_pkg
//  Purpose  : Shared constants for the bit-serial subtractor: default operand
//             width and the FSM state encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Purpose  : Host-side start/done handshake and operand/result bus of the
//             bit-serial subtractor.
//  Signals  : start (req), A/B/Bin (operands), busy, done (1-cycle pulse),
//             Diff/Bout (result, held from done until next accepted start)
//  Modports : master = host, slave = subtractor
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int N = 8
);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] Diff;
    logic         Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout
    );

endinterface
`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
`default_nettype none
// ============================================================================
//  Module   : half_subtractor / full_subtractor
//  Purpose  : One-bit subtract cells. full_subtractor computes X - Y - Bi
//             from two half subtractors and an OR of their borrows.
//  Ports    : X (minuend bit), Y (subtrahend bit), Bi (borrow in),
//             D (difference bit), Bo (borrow out)
//  Revision : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  wire logic X,
    input  wire logic Y,
    output wire logic D,
    output wire logic Bo
);

    assign D  = X ^ Y;
    assign Bo = ~X & Y;

endmodule

module full_subtractor (
    input  wire logic X,
    input  wire logic Y,
    input  wire logic Bi,
    output wire logic D,
    output wire logic Bo
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_subtractor u_hs0 (
        .X  (X),
        .Y  (Y),
        .D  (w_d1),
        .Bo (w_b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs1 (
        .X  (w_d1),
        .Y  (Bi),
        .D  (D),
        .Bo (w_b2)
    );

    assign Bo = w_b1 | w_b2;

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial N-bit subtractor, Diff = A - B - Bin (mod 2^N),
//             one bit per clock LSB first, with start/done handshake.
//  Ports    : clk, rst (sync, active high)
//             bus.start/A/B/Bin  - request and operands (captured on accept)
//             bus.busy           - high while serialising
//             bus.done           - one-cycle pulse, Diff/Bout valid
//             bus.Diff/Bout      - result, held until the next accepted start
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = c_DEFAULT_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);

    localparam int             c_CW   = $clog2(N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    logic [1:0]      r_state;
    logic [N-1:0]    r_a_sr;
    logic [N-1:0]    r_b_sr;
    logic            r_bor;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_diff;
    logic            r_bout;
    logic            r_busy;
    logic            r_done;

    logic            w_d;
    logic            w_bo;

    full_subtractor u_fs (
        .X  (r_a_sr[0]),
        .Y  (r_b_sr[0]),
        .Bi (r_bor),
        .D  (w_d),
        .Bo (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // IDLE and DONE both accept a new request; accepting from
                // DONE gives back-to-back operation without an idle gap.
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.A;
                        r_b_sr  <= bus.B;
                        r_bor   <= bus.Bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    // Result bits enter at the MSB and walk down, so after N
                    // shifts the first (LSB) bit sits at Diff[0].
                    r_diff <= {w_d, r_diff[N-1:1]};
                    r_bor  <= w_bo;
                    r_a_sr <= {1'b0, r_a_sr[N-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[N-1:1]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_bout  <= w_bo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;

endmodule
`default_nettype wire
